// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down event/position counter.
// Supports hold, increment, decrement and parallel load, with a programmable step
// and a programmable inclusive upper limit. At runtime it either wraps modulo
// (limit+1) or saturates at the bounds.
// tc is a registered one-cycle pulse marking an update that wrapped or clipped.
// at_max/at_min are combinational range flags decoded from the registered count.
// Optional feature: define UPDOWN_COUNTER_MOD_OVF_CNT_EN to add ovf_cnt[7:0],
// a saturating count of tc events cleared only by rst.
module updown_counter_mod #(
  parameter int unsigned W      = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        ctrl,
  input  logic [W-1:0]      load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      limit,
  input  logic              sat,
  output logic [W-1:0]      count,
  output logic              tc,
  output logic              at_max,
  output logic              at_min
`ifdef UPDOWN_COUNTER_MOD_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  // One guard bit so sums near limit = 2^W-1 never overflow
  localparam int unsigned XW = W + 1;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_INC  = 2'b01;
  localparam logic [1:0] CTRL_DEC  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  logic [W-1:0]  count_q, count_d;
  logic          tc_q, tc_d;

  logic [XW-1:0] cnt_x;
  logic [XW-1:0] lim_x;
  logic [XW-1:0] lim_p1_x;
  logic [XW-1:0] step_x;
  logic [XW-1:0] inc_sum_x;
  logic [XW-1:0] inc_wrap_x;
  logic [XW-1:0] dec_diff_x;
  logic [XW-1:0] dec_wrap_x;
  logic          inc_over;
  logic          dec_under;
  logic          step_zero;
  logic          step_big;
  logic          clip;
  logic          out_of_range;
  logic [W-1:0]  load_clip;

  // Widened operands shared by the increment and decrement paths
  always_comb begin
    cnt_x    = {1'b0, count_q};
    lim_x    = {1'b0, limit};
    lim_p1_x = lim_x + XW'(1);
    step_x   = XW'(step);
  end

  // Candidate results and the conditions that choose between them
  always_comb begin
    inc_sum_x    = cnt_x + step_x;
    inc_over     = (inc_sum_x > lim_x);
    inc_wrap_x   = inc_sum_x - lim_p1_x;
    dec_under    = (cnt_x < step_x);
    dec_diff_x   = cnt_x - step_x;
    dec_wrap_x   = cnt_x + lim_p1_x - step_x;
    step_zero    = (step == '0);
    // A step larger than the range would need more than one wrap, so clip instead
    step_big     = (step_x > lim_x);
    clip         = sat | step_big;
    out_of_range = (cnt_x > lim_x);
    load_clip    = (load_val > limit) ? limit : load_val;
  end

  // Next-state selection; tc only rises on a wrapping or clipping update
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (en) begin
      case (ctrl)
        CTRL_HOLD: begin
          count_d = count_q;
        end
        CTRL_LOAD: begin
          count_d = load_clip;
        end
        CTRL_INC: begin
          if (out_of_range) begin
            // Limit was lowered below the count: snap back into range
            count_d = limit;
          end else if (step_zero) begin
            count_d = count_q;
          end else if (!inc_over) begin
            count_d = W'(inc_sum_x);
          end else if (clip) begin
            count_d = limit;
            tc_d    = 1'b1;
          end else begin
            count_d = W'(inc_wrap_x);
            tc_d    = 1'b1;
          end
        end
        CTRL_DEC: begin
          if (out_of_range) begin
            count_d = limit;
          end else if (step_zero) begin
            count_d = count_q;
          end else if (!dec_under) begin
            count_d = W'(dec_diff_x);
          end else if (clip) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = W'(dec_wrap_x);
            tc_d    = 1'b1;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Counter and terminal-count pulse registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = (count_q == limit);
  assign at_min = (count_q == '0);

`ifdef UPDOWN_COUNTER_MOD_OVF_CNT_EN
  logic [7:0] ovf_q;

  // Saturating tally of tc events; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 8'd0;
    end else if (tc_d && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the team's hold/inc/dec counter.
- Adds parallel load, programmable step, a programmable upper limit, and a runtime-selectable wrap or saturate mode.
- Adds a registered terminal-count pulse and range flags.
- Used as a general event/position counter by the datapath and timer blocks. Single clock domain, fully registered outputs except the range flags.

Parameters:
- W, 8, counter width in bits (W >= 2).
- STEP_W, 4, width of the step input (STEP_W <= W).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; 0 forces hold regardless of ctrl.
- ctrl  input  2  operation: 00=hold, 01=increment, 10=decrement, 11=load.
- load_val  input  W  value used when ctrl=11.
- step  input  STEP_W  unsigned increment/decrement amount.
- limit  input  W  inclusive upper bound; legal range is 0..limit.
- sat  input  1  1=saturate at bounds, 0=wrap modulo (limit+1).
- count  output  W  registered counter value.
- tc  output  1  registered one-cycle pulse: previous update wrapped or clipped.
- at_max  output  1  combinational, count==limit.
- at_min  output  1  combinational, count==0.

Behaviour:
- **Reset:** clk is the only clock; rst is synchronous and active-high. rst=1 at a rising edge sets count=0 and tc=0, and overrides en/ctrl. Reset applied mid-sequence discards any pending operation; there is no residual tc.
- **Update timing:** one update per cycle when en=1. count reflects the operation on the edge after it is presented (latency 1). tc is valid in the same cycle as the resulting count.
- **Disabled or hold:** en=0 or ctrl=00 leaves count unchanged and sets tc=0.
- **Load (ctrl=11):** count <= min(load_val, limit). tc=0.
- **Arithmetic width:** all sums are computed in W+1 bits, so no intermediate overflow at limit = 2^W-1.
- **Increment (ctrl=01), let s = count + step:**
  - s <= limit: count <= s, tc=0.
  - s > limit and sat=1: count <= limit, tc=1.
  - s > limit and sat=0: count <= s - (limit+1), tc=1.
- **Decrement (ctrl=10):**
  - count >= step: count <= count - step, tc=0.
  - count < step and sat=1: count <= 0, tc=1.
  - count < step and sat=0: count <= count + (limit+1) - step, tc=1.
- **Oversized step:** if step > limit, inc/dec behave as saturating regardless of sat. This keeps wrap a single subtraction/addition.
- **Zero step:** step=0 makes inc/dec a hold with tc=0.
- **Out-of-range recovery:** if count > limit (limit lowered at runtime), the next inc/dec sets count <= limit with tc=0 and ignores step. Hold leaves the out-of-range value untouched.
- **Degenerate limit:** limit=0 gives count stuck at 0. Any inc/dec with step >= 1 gives tc=1.
- **tc pulse:** tc is a single-cycle pulse per event. Consecutive wrapping updates give tc high on consecutive cycles.

Optional Feature:
- **Macro:** UPDOWN_COUNTER_MOD_OVF_CNT_EN.
- **When defined:** adds output port ovf_cnt [7:0].
  - Increments on every cycle in which the registered tc update is 1, i.e. it counts events.
  - Saturates at 255 and does not wrap.
  - Cleared to 0 by rst; otherwise cannot be cleared.
- **When undefined:** the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. **Reset priority:** rst=1 with en=1, ctrl=01, count=5 -> next cycle count=0, tc=0. Release rst -> counting resumes from 0.
2. **Wrap increment:** W=8, limit=9, sat=0, step=3, start 0, ctrl=01 for 4 cycles -> count 3,6,9,2; tc=1 only with the 2.
3. **Saturating decrement:** limit=9, sat=1, step=4, load 5, then ctrl=10 twice -> count 1 then 0. tc=0 then 1; a third decrement gives count=0, tc=1.
4. **Wrap decrement at full range:** limit=255, sat=0, step=1, count=0, ctrl=10 -> count=255, tc=1, at_max=1.
5. **Load and recovery:**
   - load_val=200 with limit=100 -> count=100.
   - Lower limit to 50, ctrl=01 step=1 -> count=50, tc=0.
   - en=0 with ctrl=01 -> count holds at 50.
6. **Optional feature (macro defined):** 300 consecutive wrapping increments (limit=0, step=1) -> ovf_cnt=255 held. rst -> ovf_cnt=0.
